// File: rtl/sn_to_bn_if.sv
// Stream-in / binary-out bundle for the stochastic-to-binary decoder.
interface sn_to_bn_if #(
  parameter int unsigned NUM_BIT = 8,
  parameter int unsigned DIM     = 3000
);
  logic                         i_isgen;
  logic [DIM-1:0]               i_sn_bit;
  logic                         i_stop;
  logic [DIM-1:0][NUM_BIT-1:0]  o_x_bn;
  logic                         o_valid;
  logic                         o_busy;

  modport master (
    output i_isgen, i_sn_bit, i_stop,
    input  o_x_bn, o_valid, o_busy
  );

  modport slave (
    input  i_isgen, i_sn_bit, i_stop,
    output o_x_bn, o_valid, o_busy
  );
endinterface

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary decoder: counts ones per lane over a window of up to
// 2**NUM_BIT samples and reports the saturated count with a one-cycle pulse.
module sn_to_bn #(
  parameter int unsigned NUM_BIT = 8,
  parameter int unsigned DIM     = 3000
) (
  input  logic        i_clk_sn_bn,
  input  logic        i_rst_n_sn_bn,
  sn_to_bn_if.slave   bus
);

  localparam int unsigned CW = NUM_BIT + 1;
  localparam logic [CW-1:0] WIN  = CW'(1) << NUM_BIT;
  localparam logic [CW-1:0] MAXV = WIN - CW'(1);

  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;

  state_t                       r_state;
  logic                         r_isgen_d;
  logic [DIM-1:0][CW-1:0]       r_cnt;
  logic [CW-1:0]                r_samples;
  logic [DIM-1:0][NUM_BIT-1:0]  r_x_bn;
  logic                         r_valid;
  logic                         r_busy;

  logic [DIM-1:0][CW-1:0]       w_cnt_nxt;
  logic [DIM-1:0][NUM_BIT-1:0]  w_sat_cur;
  logic [DIM-1:0][NUM_BIT-1:0]  w_sat_nxt;
  logic [CW-1:0]                w_samples_nxt;
  logic                         w_start;

  assign w_samples_nxt = r_samples + CW'(1);
  assign w_start       = bus.i_isgen & ~r_isgen_d;

  // Per-lane next count plus saturated views of current and next count.
  always_comb begin
    w_cnt_nxt = '0;
    w_sat_cur = '0;
    w_sat_nxt = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      w_cnt_nxt[i] = r_cnt[i] + CW'(bus.i_sn_bit[i]);
      w_sat_cur[i] = (r_cnt[i] > MAXV) ? MAXV[NUM_BIT-1:0] : r_cnt[i][NUM_BIT-1:0];
      w_sat_nxt[i] = (w_cnt_nxt[i] > MAXV) ? MAXV[NUM_BIT-1:0] : w_cnt_nxt[i][NUM_BIT-1:0];
    end
  end

  always_ff @(posedge i_clk_sn_bn or negedge i_rst_n_sn_bn) begin
    if (!i_rst_n_sn_bn) begin
      r_state   <= IDLE;
      r_isgen_d <= 1'b0;
      r_cnt     <= '0;
      r_samples <= '0;
      r_x_bn    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_isgen_d <= bus.i_isgen;
      r_valid   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start && !bus.i_stop) begin
            r_state <= ACC;
            r_busy  <= 1'b1;
            for (int i = 0; i < int'(DIM); i++) begin
              r_cnt[i] <= CW'(bus.i_sn_bit[i]);
            end
            r_samples <= CW'(1);
          end
        end
        ACC: begin
          // Abort takes priority over a closing window.
          if (bus.i_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!bus.i_isgen) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_x_bn  <= w_sat_cur;
            r_valid <= 1'b1;
          end else begin
            r_cnt     <= w_cnt_nxt;
            r_samples <= w_samples_nxt;
            if (w_samples_nxt == WIN) begin
              r_state <= WAIT;
              r_busy  <= 1'b0;
              r_x_bn  <= w_sat_nxt;
              r_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!bus.i_isgen) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_x_bn  = r_x_bn;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = r_busy;

endmodule

// File: tb/tb_sn_to_bn.sv
// Scoreboard bench for sn_to_bn: expected window results are queued at
// stimulus time and matched by an independent monitor on every o_valid.
module tb_sn_to_bn;

  localparam int unsigned NB  = 8;
  localparam int unsigned DIM = 6;
  localparam int          W   = 256;

  typedef struct {
    logic [DIM-1:0][NB-1:0] v;
    int                     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t                   exp_q[$];
  logic [DIM-1:0][NB-1:0] hold = '0;
  logic [DIM-1:0]         gen_bits [0:W+7];
  int                     lane_x [DIM];

  sn_to_bn_if #(.NUM_BIT(NB), .DIM(DIM)) bus ();

  sn_to_bn #(.NUM_BIT(NB), .DIM(DIM)) dut (
    .i_clk_sn_bn   (clk),
    .i_rst_n_sn_bn (rst_n),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every valid pulse must match the oldest expected window, on time;
  // between pulses the output must hold the last reported value.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = '0;
    end else if (bus.o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got o_x_bn=%h, required no pulse", bus.o_x_bn);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.o_x_bn !== e.v) begin
          errors++;
          $display("FAIL x_bn: got %h, required %h", bus.o_x_bn, e.v);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL valid_latency: got cycle %0d, required cycle %0d", cyc, e.due);
        end
        hold = e.v;
      end
    end else begin
      checks++;
      if (bus.o_x_bn !== hold) begin
        errors++;
        $display("FAIL x_bn_hold: got %h, required %h", bus.o_x_bn, hold);
      end
    end
  end

  function automatic int bitrev8(input int t);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) if (((t >> b) & 1) != 0) r |= 1 << (7 - b);
    return r;
  endfunction

  // Weighted-binary encoder: lane with value x has x ones over W slots, last slot 0.
  task automatic fill_enc();
    for (int t = 0; t < W + 8; t++)
      for (int l = 0; l < int'(DIM); l++)
        gen_bits[t][l] = (t < W) && (bitrev8(t) < lane_x[l]);
  endtask

  task automatic fill_rand();
    for (int t = 0; t < W + 8; t++) gen_bits[t] = DIM'($urandom);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // n: samples with isgen high before it falls (256 = full window), extra: more high
  // cycles after n, stop_at/rst_at: iteration of abort or reset (-1 = none).
  task automatic run_window(input int n, input int extra, input int stop_at,
                            input int rst_at, input bit drain);
    exp_t e;
    int   sum [DIM];
    int   nc;
    int   last;
    bit   aborted;
    bit   exp_busy;
    nc      = (n < W) ? n : W;
    last    = n + extra;
    aborted = (rst_at >= 0) || (stop_at >= 0 && stop_at <= n && stop_at < W);
    for (int l = 0; l < int'(DIM); l++) begin
      sum[l] = 0;
      for (int t = 0; t < nc; t++)
        if (stop_at < 0 || t < stop_at) sum[l] += int'(gen_bits[t][l]);
      e.v[l] = (sum[l] > W - 1) ? NB'(W - 1) : NB'(sum[l]);
    end
    e.due = cyc + ((n >= W) ? W : n + 1);
    if (!aborted) exp_q.push_back(e);

    for (int t = 0; t <= last; t++) begin
      bus.i_isgen  = (t < last);
      bus.i_stop   = (t == stop_at);
      bus.i_sn_bit = (t < last) ? gen_bits[t] : DIM'($urandom);
      @(negedge clk);
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_x_bn", 64'(bus.o_x_bn), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        bus.i_isgen = 1'b0;
        bus.i_stop  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      exp_busy = (stop_at != 0) && (t != stop_at) && ((n >= W) ? (t < W - 1) : (t < n));
      chk("busy", 64'(bus.o_busy), 64'(exp_busy));
      if (t == stop_at) break;
    end
    bus.i_isgen = 1'b0;
    bus.i_stop  = 1'b0;
    if (drain) begin
      repeat (3) @(negedge clk);
      #1;
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    bus.i_isgen  = 1'b0;
    bus.i_stop   = 1'b0;
    bus.i_sn_bit = '0;
    repeat (2) @(negedge clk);
    chk("reset_x_bn", 64'(bus.o_x_bn), 64'd0);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Encoder streams across lanes, full window.
    lane_x = '{0, 1, 100, 255, 37, 200};
    fill_enc();
    run_window(W, 0, -1, -1, 1'b1);

    // All-ones lanes saturate; extra high cycles sit in WAIT without restarting.
    for (int t = 0; t < W + 8; t++) gen_bits[t] = '1;
    run_window(W, 5, -1, -1, 1'b1);

    // Prior result 37, then abort at sample 50 of an x=100 window.
    lane_x = '{37, 37, 37, 37, 37, 37};
    fill_enc();
    run_window(W, 0, -1, -1, 1'b1);
    lane_x = '{100, 100, 100, 100, 100, 100};
    fill_enc();
    run_window(W, 0, 50, -1, 1'b1);

    // Short window of 10 samples, lane 0 carries 6 ones.
    fill_rand();
    for (int t = 0; t < 10; t++) gen_bits[t][0] = ((10'b1011010011 >> t) & 10'd1) != 0;
    run_window(10, 0, -1, -1, 1'b1);

    // Reset mid-window at sample 120, then a full x=200 window.
    lane_x = '{150, 150, 150, 150, 150, 150};
    fill_enc();
    run_window(W, 0, -1, 120, 1'b1);
    lane_x = '{200, 200, 200, 200, 200, 200};
    fill_enc();
    run_window(W, 0, -1, -1, 1'b1);

    // Back-to-back windows separated by a single low cycle.
    lane_x = '{17, 17, 17, 17, 17, 17};
    fill_enc();
    run_window(W, 0, -1, -1, 1'b0);
    lane_x = '{250, 250, 250, 250, 250, 250};
    fill_enc();
    run_window(W, 0, -1, -1, 1'b1);

    // Stop coinciding with isgen fall, and stop on the start cycle.
    fill_rand();
    run_window(20, 0, 20, -1, 1'b1);
    fill_rand();
    run_window(10, 0, 0, -1, 1'b1);

    // Randomized windows, some aborted.
    for (int k = 0; k < 10; k++) begin
      int n;
      int s;
      n = int'($urandom_range(1, W));
      s = -1;
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, (n < W) ? n : W - 1));
      fill_rand();
      run_window(n, 0, s, -1, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("final_pending", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sn_to_bn.md
SN_TO_BN -- requirements
Module: sn_to_bn

Interface
REQ-001 SHALL have parameter NUM_BIT, default 8, meaning binary word width; stream window is 2**NUM_BIT cycles.
REQ-002 SHALL have parameter DIM, default 3000, meaning number of parallel lanes.
REQ-003 SHALL have port i_clk_sn_bn  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n_sn_bn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_isgen  input  1  stream-valid; high while a stochastic window is presented.
REQ-006 SHALL have port i_sn_bit  input  [DIM] x 1  one stochastic bit per lane per cycle.
REQ-007 SHALL have port i_stop  input  1  abort current window.
REQ-008 SHALL have port o_x_bn  output  [DIM] x NUM_BIT  decoded binary value per lane.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse, o_x_bn freshly updated.
REQ-010 SHALL have port o_busy  output  1  high while state is ACC.

Function
REQ-011 SHALL implement states IDLE, ACC, WAIT, all registered.
REQ-012 SHALL register i_isgen each cycle into isgen_d; start condition = i_isgen=1 and isgen_d=0.
REQ-013 IDLE: on start condition -> ACC; per-lane counter loaded with i_sn_bit[i]; sample count loaded with 1.
REQ-014 ACC: each edge with i_isgen=1 and i_stop=0 -> counter[i] += i_sn_bit[i], sample count += 1.
REQ-015 Per-lane counter SHALL be NUM_BIT+1 bits internally; sample count NUM_BIT+1 bits.
REQ-016 Window closes at the edge where, in ACC, i_isgen=0 (that sample not counted) -> IDLE.
REQ-017 Window also closes at the edge completing the 2**NUM_BIT-th counted sample -> WAIT.
REQ-018 On window close: o_x_bn[i] registered = min(counter[i], 2**NUM_BIT-1) (saturate); o_valid=1 next cycle only.
REQ-019 o_valid SHALL be high exactly one cycle per closed window; latency 1 cycle after last counted sample edge.
REQ-020 WAIT: stay until i_isgen=0 sampled, then -> IDLE; bits ignored in WAIT.
REQ-021 i_stop=1 in ACC -> IDLE at that edge; sample not counted; no o_valid; o_x_bn holds previous value.
REQ-022 i_stop and i_isgen fall same edge -> i_stop wins (abort, no o_valid).
REQ-023 i_stop in IDLE or WAIT SHALL have no effect; start condition with i_stop=1 in IDLE SHALL NOT start.
REQ-024 o_x_bn SHALL hold between windows; change only with o_valid.
REQ-025 o_busy = (state==ACC).
REQ-026 Window of N<2**NUM_BIT samples SHALL still report raw ones count (no rescaling).
REQ-027 Decoding SHALL be exact inverse of weighted-binary stream generation: stream for value x (x ones in 2**NUM_BIT slots, final slot 0) decodes to x.

Reset
REQ-028 Reset low SHALL asynchronously force state=IDLE, isgen_d=0, counters=0, sample count=0, o_x_bn=all 0, o_valid=0, o_busy=0.
REQ-029 Reset mid-ACC SHALL discard window; no o_valid after release.
REQ-030 After release, i_isgen already high SHALL count as start condition (isgen_d=0).

Verification
REQ-031 Lanes driven with encoder streams for x=0,1,100,255 over 256-cycle window -> one o_valid, o_x_bn={0,1,100,255}.
REQ-032 Lane all-ones for 256 samples -> o_x_bn=255 (saturated), state WAIT until i_isgen=0.
REQ-033 i_stop pulsed at sample 50 of x=100 window after prior result 37 -> no o_valid, o_x_bn stays 37, o_busy drops next cycle.
REQ-034 i_isgen high 10 cycles with 6 ones -> o_valid one cycle after fall edge, o_x_bn=6.
REQ-035 Reset asserted at sample 120 -> all outputs 0 immediately; next full window x=200 -> o_x_bn=200.
REQ-036 Back-to-back windows (i_isgen low 1 cycle between) x=17 then x=250 -> two o_valid pulses, values 17, 250.
